game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60; number of frame ticks per countdown second (range 2..255).
REQ-002 Parameter START_LIVES, default 3; lives loaded on game start (range 1..3).
REQ-003 Parameter COUNTDOWN_S, default 3; countdown seconds before play (range 1..3).
REQ-004 Parameter OVER_FRAMES, default 180; frames spent in OVER before automatic return to MENU (range 1..1023).
REQ-005 clk  input  1  system clock, the 65 MHz pixel clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 key  input  4  keyboard code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 start (Enter), 6 pause (Esc); codes 7..15 are ignored.
REQ-008 vs  input  1  vertical sync from the VGA timing chain, same clock domain.
REQ-009 hit  input  1  one-cycle pulse from the gameplay datapath: the player lost a life.
REQ-010 state  output  3  current state: 0 MENU, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 OVER.
REQ-011 frame_tick  output  1  one-cycle pulse per frame.
REQ-012 run  output  1  datapath update enable.
REQ-013 game_rst  output  1  one-cycle datapath reset pulse.
REQ-014 move  output  4  one-hot direction {right,left,down,up}, valid for the current frame.
REQ-015 lives  output  2  remaining lives.
REQ-016 countdown  output  2  seconds remaining in COUNTDOWN, 0 in all other states.

Function
REQ-017 frame_tick SHALL be asserted for exactly one cycle, in the cycle after a registered vs sample goes from 0 to 1.
REQ-018 A key event SHALL be a one-cycle internal strobe raised when the registered key value changes to a nonzero value; holding a key produces exactly one event.
REQ-019 MENU: a start event SHALL make the following transitions: go to COUNTDOWN, lives<=START_LIVES, countdown<=COUNTDOWN_S, frame counter<=0, and assert game_rst for one cycle.
REQ-020 COUNTDOWN: each frame_tick SHALL increment the frame counter.
REQ-021 COUNTDOWN: at FRAMES_PER_SEC-1 the frame counter SHALL wrap to 0 and countdown SHALL decrement; a wrap while countdown==1 SHALL enter PLAY with countdown=0.
REQ-022 COUNTDOWN: a pause event SHALL return to MENU.
REQ-023 PLAY: run SHALL be 1, and in no other state.
REQ-024 PLAY: move SHALL be updated only on frame_tick, from the currently held direction key (codes 1..4), and be 0 when no direction key is held.
REQ-025 move SHALL be 0 outside PLAY.
REQ-026 PLAY: on hit with lives>1, lives SHALL decrement and the state SHALL go to COUNTDOWN, with countdown and the frame counter reloaded and no game_rst.
REQ-027 PLAY: on hit with lives==1, lives SHALL become 0 and the state SHALL go to OVER, with the frame counter cleared.
REQ-028 PLAY: a pause event SHALL go to PAUSE.
REQ-029 PLAY: if hit and a pause event occur in the same cycle, hit SHALL win and the pause event is dropped.
REQ-030 PAUSE: run=0 and move=0; lives and the datapath state SHALL be held.
REQ-031 PAUSE: a pause event SHALL return to PLAY; a start event SHALL go to MENU.
REQ-032 OVER: the frame counter (10-bit) SHALL count frame_ticks; on reaching OVER_FRAMES, or on a start event, the state SHALL go to MENU.
REQ-033 hit SHALL be ignored in every state except PLAY.
REQ-034 Key events with ignored codes SHALL cause no state change.
REQ-035 All outputs SHALL be registered, with one cycle of latency from the triggering input or event.
REQ-036 lives SHALL never wrap below 0.

Reset
REQ-037 While rst=1 at a clock edge, the block SHALL set: state=MENU, frame_tick=0, run=0, game_rst=0, move=0, lives=0, countdown=0, frame counter=0, and clear the key and vs history registers.
REQ-038 A reset asserted mid-operation (any state) SHALL take effect on the next edge; no event latched before reset SHALL act after it.
REQ-039 A key held through reset release SHALL NOT generate an event.

Verification
REQ-040 Reset, then key=5 for 10 cycles -> exactly one game_rst pulse; state=1, lives=3, countdown=3.
REQ-041 From COUNTDOWN, 180 vs rising edges -> countdown steps 3,2,1 every 60 ticks; state=2 and run=1 after tick 180.
REQ-042 PLAY with key=4 held -> move=4'b1000, changing only on frame_tick; key=0 -> move=0 on the next tick.
REQ-043 PLAY with lives=3 -> three hit pulses spaced by full countdowns give lives 2, 1, 0; the third hit gives state=4, and 180 ticks later state=0.
REQ-044 PLAY: hit and an Esc event in the same cycle -> state=1 and lives decremented; PAUSE is not entered.
REQ-045 PAUSE, then rst for 1 cycle with key=6 held -> state=0; no event after reset release until key returns to 0 and is pressed again.

Source files
------------

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: player inputs, frame sync and status outputs of the game controller.
interface game_ctrl_if;
    logic [3:0] key;
    logic       vs;
    logic       hit;
    logic [2:0] state;
    logic       frame_tick;
    logic       run;
    logic       game_rst;
    logic [3:0] move;
    logic [1:0] lives;
    logic [1:0] countdown;
    modport master (output key, vs, hit, input state, frame_tick, run, game_rst, move, lives, countdown);
    modport slave (input key, vs, hit, output state, frame_tick, run, game_rst, move, lives, countdown);
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: menu/countdown/play/pause/over sequencer with frame tick, key edge events and lives.
module game_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int START_LIVES    = 3,
    parameter int COUNTDOWN_S    = 3,
    parameter int OVER_FRAMES    = 180
) (
    input logic        clk,
    input logic        rst,
    game_ctrl_if.slave g
);
    typedef enum logic [2:0] {MENU, CD, PLAY, PAUSE, OVER} st_t;
    st_t        st, nxt;
    logic [3:0] key_q, key_d, move_q, move_n, dir;
    logic       arm, vs_q, vs_d, ft, run_q, grst_q, grst_n;
    logic [9:0] cnt, cnt_n;
    logic [1:0] lives_q, lives_n, cd_q, cd_n;
    logic       ev, start_ev, pause_ev, sec_end, over_end;
    // arm stays low after reset until the raw key has been seen released
    assign ev       = arm && key_q != key_d && key_q != 4'd0;
    assign start_ev = ev && key_q == 4'd5;
    assign pause_ev = ev && key_q == 4'd6;
    assign sec_end  = ft && cnt == 10'(FRAMES_PER_SEC - 1);
    assign over_end = ft && cnt == 10'(OVER_FRAMES - 1);
    assign dir = key_q == 4'd1 ? 4'b0001 : key_q == 4'd2 ? 4'b0010 :
                 key_q == 4'd3 ? 4'b0100 : key_q == 4'd4 ? 4'b1000 : 4'b0000;
    always_ff @(posedge clk)
        st <= rst ? MENU : nxt;
    always_comb begin
        nxt = st;
        case (st)
            MENU:    nxt = start_ev ? CD : MENU;
            CD:      nxt = pause_ev ? MENU : (sec_end && cd_q == 2'd1) ? PLAY : CD;
            PLAY:    nxt = g.hit ? (lives_q > 2'd1 ? CD : OVER) : pause_ev ? PAUSE : PLAY;
            PAUSE:   nxt = pause_ev ? PLAY : start_ev ? MENU : PAUSE;
            OVER:    nxt = (start_ev || over_end) ? MENU : OVER;
            default: nxt = MENU;
        endcase
    end
    always_comb begin
        cnt_n   = cnt;
        lives_n = lives_q;
        cd_n    = cd_q;
        grst_n  = 1'b0;
        move_n  = 4'd0;
        case (st)
            MENU: if (start_ev) begin
                lives_n = 2'(START_LIVES);
                cd_n    = 2'(COUNTDOWN_S);
                cnt_n   = 10'd0;
                grst_n  = 1'b1;
            end
            CD: begin
                cnt_n = (pause_ev || sec_end) ? 10'd0 : ft ? cnt + 10'd1 : cnt;
                cd_n  = pause_ev ? 2'd0 : sec_end ? cd_q - 2'd1 : cd_q;
            end
            PLAY: if (g.hit) begin
                cnt_n   = 10'd0;
                lives_n = lives_q > 2'd1 ? lives_q - 2'd1 : 2'd0;
                cd_n    = lives_q > 2'd1 ? 2'(COUNTDOWN_S) : 2'd0;
            end else
                move_n = pause_ev ? 4'd0 : ft ? dir : move_q;
            OVER: cnt_n = (start_ev || over_end) ? 10'd0 : ft ? cnt + 10'd1 : cnt;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= 4'd0;
            key_d   <= 4'd0;
            arm     <= 1'b0;
            vs_q    <= 1'b0;
            vs_d    <= 1'b0;
            ft      <= 1'b0;
            run_q   <= 1'b0;
            grst_q  <= 1'b0;
            move_q  <= 4'd0;
            lives_q <= 2'd0;
            cd_q    <= 2'd0;
            cnt     <= 10'd0;
        end else begin
            key_q   <= g.key;
            key_d   <= key_q;
            arm     <= arm || g.key == 4'd0;
            vs_q    <= g.vs;
            vs_d    <= vs_q;
            ft      <= vs_q && !vs_d;
            run_q   <= nxt == PLAY;
            grst_q  <= grst_n;
            move_q  <= move_n;
            lives_q <= lives_n;
            cd_q    <= cd_n;
            cnt     <= cnt_n;
        end
    end
    assign g.state      = st;
    assign g.frame_tick = ft;
    assign g.run        = run_q;
    assign g.game_rst   = grst_q;
    assign g.move       = move_q;
    assign g.lives      = lives_q;
    assign g.countdown  = cd_q;
endmodule
